// File: rtl/dfe_pkg.sv
// ============================================================================
// Module      : dfe_pkg
// Description : Shared types and default constants for the DFE sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dfe_pkg;

    localparam int DFE_DATA_BW        = 8;
    localparam int DFE_WARMUP_SAMPLES = 4;
    localparam int DFE_FRAME_LEN      = 50;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } dfe_state_t;

endpackage

`default_nettype wire

// File: rtl/dfe_sequencer_if.sv
// ============================================================================
// Module      : dfe_sequencer_if
// Description : Decimator input strobe and framed valid/ready output stream.
//               Signal suffixes are from the sequencer's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dfe_sequencer_if #(
    parameter int DATA_BW = 8
);
    logic [DATA_BW-1:0] dec_data_i;
    logic               dec_valid_i;
    logic [DATA_BW-1:0] data_o;
    logic               valid_o;
    logic               last_o;
    logic               ready_i;

    // Sequencer side
    modport slave (
        input  dec_data_i, dec_valid_i, ready_i,
        output data_o, valid_o, last_o
    );

    // Decimator / consumer side
    modport master (
        output dec_data_i, dec_valid_i, ready_i,
        input  data_o, valid_o, last_o
    );
endinterface

`default_nettype wire

// File: rtl/dfe_hold_reg.sv
// ============================================================================
// Module      : dfe_hold_reg
// Description : One-entry valid/ready holding register (data + last flag)
//               with sticky overflow on samples that find it full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfe_hold_reg #(
    parameter int DATA_BW = 8
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    input  wire logic               clr_ovf_i,
    input  wire logic               load_i,
    input  wire logic [DATA_BW-1:0] data_i,
    input  wire logic               last_i,
    input  wire logic               ready_i,
    output logic      [DATA_BW-1:0] data_o,
    output logic                    valid_o,
    output logic                    last_o,
    output logic                    overflow_o,
    output logic                    loaded_o,
    output logic                    accept_o
);

    logic [DATA_BW-1:0] data_q;
    logic               valid_q;
    logic               last_q;
    logic               ovf_q;

    // A slot frees up in the same cycle the consumer takes the held sample
    assign accept_o = valid_q & ready_i;
    assign loaded_o = load_i & (~valid_q | ready_i);

    // Load / accept / overflow bookkeeping; held data stays put while stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (loaded_o) begin
                data_q  <= data_i;
                valid_q <= 1'b1;
                last_q  <= last_i;
            end else if (accept_o) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
            if (clr_ovf_i) begin
                ovf_q <= 1'b0;
            end else if (load_i && !loaded_o) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/dfe_sequencer.sv
// ============================================================================
// Module      : dfe_sequencer
// Description : Sequences the CIC/decimator chain: enable control, warm-up
//               discard, framing with valid/ready output and graceful stop.
//               Optional macro DFE_SEQ_FRAME_CNT_EN builds the completed-frame
//               counter; otherwise frame_count_o is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfe_sequencer
    import dfe_pkg::*;
#(
    parameter int DATA_BW        = DFE_DATA_BW,
    parameter int WARMUP_SAMPLES = DFE_WARMUP_SAMPLES,
    parameter int FRAME_LEN      = DFE_FRAME_LEN
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        start_i,
    input  wire logic        stop_i,
    output logic             en_o,
    output logic             busy_o,
    output logic             overflow_o,
    output logic [15:0]      frame_count_o,
    dfe_sequencer_if.slave   bus
);

    localparam int WU_W  = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_SAMPLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    dfe_state_t       state_q, state_d;
    logic [WU_W-1:0]  wu_cnt_q, wu_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             active_q;
    logic             start_clr;
    logic             load_req;
    logic             loaded;
    logic             accept;

    // Holding register owns the handshake and overflow flag
    dfe_hold_reg #(
        .DATA_BW (DATA_BW)
    ) u_hold (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_ovf_i  (start_clr),
        .load_i     (load_req),
        .data_i     (bus.dec_data_i),
        .last_i     (idx_q == IDX_LAST),
        .ready_i    (bus.ready_i),
        .data_o     (bus.data_o),
        .valid_o    (bus.valid_o),
        .last_o     (bus.last_o),
        .overflow_o (overflow_o),
        .loaded_o   (loaded),
        .accept_o   (accept)
    );

    // Next-state, counter updates and load request
    always_comb begin
        state_d   = state_q;
        wu_cnt_d  = wu_cnt_q;
        idx_d     = idx_q;
        start_clr = 1'b0;
        load_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = WARMUP;
                    wu_cnt_d  = '0;
                    idx_d     = '0;
                    start_clr = 1'b1;
                end
            end
            WARMUP: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (bus.dec_valid_i) begin
                    if (wu_cnt_q == WU_LAST) begin
                        state_d  = RUN;
                        wu_cnt_d = '0;
                    end else begin
                        wu_cnt_d = wu_cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                load_req = bus.dec_valid_i;
                if (stop_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The frame's final sample leaving ends the run; a sample
                // arriving alongside it is silently discarded.
                if (accept && bus.last_o) begin
                    state_d = IDLE;
                end else begin
                    load_req = bus.dec_valid_i;
                end
            end
            default: state_d = IDLE;
        endcase
        if (loaded) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // State, counters and registered enable
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wu_cnt_q <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wu_cnt_q <= wu_cnt_d;
            idx_q    <= idx_d;
            active_q <= (state_d != IDLE);
        end
    end

    assign en_o   = active_q;
    assign busy_o = active_q;

`ifdef DFE_SEQ_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed frames: counts accepted last samples, wraps naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
        end else if (start_clr) begin
            frame_cnt_q <= '0;
        end else if (accept && bus.last_o) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count_o = frame_cnt_q;
`else
    assign frame_count_o = '0;
`endif

endmodule

`default_nettype wire
